// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider: FSM encodings, handshake
// levels and the bus types of the HI/LO write path.
package div_pkg;

  localparam int RegW = 32;
  typedef logic [RegW-1:0]   reg_bus_t;
  typedef logic [2*RegW-1:0] double_reg_bus_t;

  localparam reg_bus_t ZeroWord = '0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider. result_o = {remainder, quotient},
// valid while ready_o is high; held until the EX stage drops start_i.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W) + 1;

  div_state_e           state;
  logic [CW-1:0]        cnt;
  logic [2*DATA_W:0]    dividend;
  logic [DATA_W-1:0]    divisor;
  logic                 sign1, sign2, sgn;

  logic [DATA_W:0]      diff;
  logic [DATA_W-1:0]    op1_abs, op2_abs;
  logic [DATA_W-1:0]    quot, rem, quot_fix, rem_fix;

  always_comb begin
    diff     = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    op1_abs  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quot     = dividend[DATA_W-1:0];
    rem      = dividend[2*DATA_W:DATA_W+1];
    // Remainder follows the dividend's sign, quotient the XOR of both.
    quot_fix = (sgn && (sign1 ^ sign2)) ? -quot : quot;
    rem_fix  = (sgn && sign1) ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sgn      <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              dividend <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
              divisor  <= op2_abs;
              sign1    <= opdata1_i[DATA_W-1];
              sign2    <= opdata2_i[DATA_W-1];
              sgn      <= signed_div_i;
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            dividend <= '0;
            state    <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
          end else if (cnt != CW'(DATA_W)) begin
            if (diff[DATA_W])
              dividend <= dividend << 1;
            else
              dividend <= {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
            cnt <= cnt + CW'(1);
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o  <= DivResultReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues expected results from an
// arithmetic reference; a monitor checks each rising ready_o.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct { logic [63:0] res; int due; } exp_t;
  exp_t sb[$];
  exp_t e;

  function automatic logic [63:0] model(bit s, logic [31:0] a, logic [31:0] b);
    int sa, sb_, q, r;
    if (b == 0) return 64'h0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb_ = $signed(b);
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest queued expectation.
  bit prev_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ready_o && !prev_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(ready_o), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
    prev_rdy = ready_o;
  end

  task automatic push_exp(bit s, logic [31:0] a, logic [31:0] b);
    sb.push_back('{res: model(s, a, b), due: cyc + 1 + ((b == 0) ? 1 : 33)});
  endtask

  task automatic wait_ready(string name, bit toggle, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
      else if (toggle) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end
    if (!got) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic run_div(bit s, logic [31:0] a, logic [31:0] b, int extra, bit toggle);
    logic [63:0] held;
    bit got;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    push_exp(s, a, b);
    wait_ready("run", toggle, got);
    if (!got) sb.delete();
    held = result_o;
    repeat (extra) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'(1));
      chk("hold_result", result_o, held);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("release_ready", 64'(ready_o), 64'(0));
    chk("release_result", result_o, 64'h0);
  endtask

  task automatic watch_quiet(string name, int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [31:0] a, b;
    bit s;
    #3;
    chk("reset_ready", 64'(ready_o), 64'(0));
    chk("reset_result", result_o, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch_quiet("idle_quiet", 3);

    run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_div(1'b1, 32'd5, 32'd0, 0, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 2, 1'b0);

    // Annul at cnt=10 must abandon the division.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    watch_quiet("annul_quiet", 40);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 1'b0);

    // start and annul together in the idle state: annul wins.
    @(negedge clk);
    opdata1_i = 32'd5; opdata2_i = 32'd1; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    watch_quiet("start_annul_quiet", 40);

    // Asynchronous reset at cnt=20.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd123456; opdata2_i = 32'd789; start_i = 1'b1;
    repeat (21) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ready", 64'(ready_o), 64'(0));
    chk("async_rst_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    watch_quiet("post_rst_quiet", 40);
    run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd7; start_i = 1'b1;
    push_exp(1'b0, 32'd50, 32'd7);
    wait_ready("rst_hold", 1'b0, got);
    if (!got) sb.delete();
    #2 rst = 1'b0;
    #1;
    chk("rst_hold_ready", 64'(ready_o), 64'(0));
    chk("rst_hold_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'h0;
        default: b = -32'($urandom_range(1, 20));
      endcase
      run_div(s, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
